// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch and load/store requesters.
// One transaction at a time, with round-robin arbitration when both request.
module mem_port_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_raddress,
  output logic [ADDR_W-1:0] mem_waddress,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_dataout
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam int WaitInit = (READ_LAT > 1) ? READ_LAT - 2 : 0;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  // Owner encoding: 0 = fetch, 1 = data. On a tie the requester not served last wins.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    i_rvalid     = 1'b0;
    d_rvalid     = 1'b0;
    mem_wr       = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          owner_d = d_req && (!i_req || !last_owner_q);
          addr_d  = owner_d ? d_addr : i_addr;
          we_d    = owner_d && d_we;
          wdata_d = owner_d ? d_wdata : '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        i_gnt  = !owner_q;
        d_gnt  = owner_q;
        mem_wr = we_q;
        if (we_q) begin
          last_owner_d = owner_q;
          state_d      = IDLE;
        end else if (READ_LAT > 1) begin
          cnt_d   = 3'(WaitInit);
          state_d = WAIT;
        end else begin
          state_d = RESP;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        i_rvalid = !owner_q;
        d_rvalid = owner_q;
        if (owner_q) begin
          d_rdata_d = mem_dataout;
        end else begin
          i_rdata_d = mem_dataout;
        end
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= 3'd0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // The read data bypasses the register during RESP and holds the last value otherwise.
  assign i_rdata      = i_rdata_d;
  assign d_rdata      = d_rdata_d;
  assign busy         = (state_q != IDLE);
  assign mem_raddress = addr_q;
  assign mem_waddress = addr_q;
  assign mem_datain   = wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter that shares one 64-bit data memory between the instruction-fetch requester (PC side) and the load/store requester (ALUOut/B side) of the multicycle RISC-V core. It serialises accesses, issues one memory transaction at a time, and returns read data with a valid pulse. The block sits between the control/datapath and a unified Memoria64-style array, so the core runs from one memory instead of two.

## Interface
- ADDR_W, 64, address width of both requesters and the memory.
- DATA_W, 64, data width.
- READ_LAT, 1, memory read latency in cycles from address presented to mem_dataout valid; legal range 1..7.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- i_req  in  1  fetch read request; held high until i_gnt.
- i_addr  in  ADDR_W  fetch address; stable while i_req high.
- i_gnt  out  1  one-cycle pulse, fetch request accepted.
- i_rvalid  out  1  one-cycle pulse, i_rdata valid.
- i_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request; held high until d_gnt.
- d_we  in  1  1 = store, 0 = load; stable while d_req high.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  one-cycle pulse, data request accepted.
- d_rvalid  out  1  one-cycle pulse, d_rdata valid (loads only).
- d_rdata  out  DATA_W  load data.
- busy  out  1  high whenever state is not IDLE.
- mem_raddress  out  ADDR_W  memory read address.
- mem_waddress  out  ADDR_W  memory write address.
- mem_datain  out  DATA_W  memory write data.
- mem_wr  out  1  memory write enable.
- mem_dataout  in  DATA_W  memory read data.

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: if any req, select owner, latch owner's addr/we/wdata into internal registers, go ACCESS. No req: stay.
- Arbitration: only one req → that one. Both → round-robin on last_owner bit: grant the requester not served last. last_owner resets to D, so fetch wins the first tie.
- ACCESS (one cycle): owner's gnt = 1; mem_raddress = mem_waddress = latched addr; mem_datain = latched wdata; mem_wr = latched we. Store → IDLE (no rvalid). Load/fetch → WAIT if READ_LAT > 1, else RESP.
- WAIT: down-counter loaded with READ_LAT-2 on entry; addresses held; → RESP when counter = 0.
- RESP (one cycle): owner's rvalid = 1; owner's rdata = mem_dataout and the same value captured into that owner's rdata register; update last_owner; → IDLE.
- rdata outputs hold last returned value outside RESP; the other requester's rdata is unaffected.
- Fetch port never writes; mem_wr only from a latched d_we.
- Requests arriving while busy are not sampled until IDLE; the requester keeps req high.
- Starvation bound: a held request waits at most one complete transaction of the other requester.

## Timing
- Reset (reset = 0 at an edge): state IDLE, last_owner = D, counter 0, all gnt/rvalid/mem_wr/busy = 0, i_rdata = d_rdata = 0, mem addresses/datain = 0. Reset mid-transaction aborts it: no rvalid, no mem_wr after that edge.
- Request sampled high in IDLE in cycle n: gnt and memory address in cycle n+1.
- Read: rvalid in cycle n+1+READ_LAT (READ_LAT = 1 → n+2). Write: mem_wr in n+1, back to IDLE n+2.
- Back-to-back throughput: read every READ_LAT+2 cycles, write every 2 cycles.
- Memory outputs stable from ACCESS through RESP; mem_wr high only in ACCESS.
- gnt and rvalid never high in the same cycle; at most one of i_*/d_* strobes high per cycle.

## Test plan
- Reset: hold reset = 0 two cycles with i_req = d_req = 1 → all strobes 0, busy 0; release → i_gnt one cycle later (fetch wins first tie).
- Single fetch, READ_LAT = 1, i_addr = 0x40, memory word 0x00000013 → i_gnt in n+1, i_rvalid with i_rdata = 0x13 in n+2, d_* strobes 0.
- Store then load: d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF_CAFEF00D → mem_wr one cycle in n+1, no d_rvalid; load 0x100 → d_rdata = 0xDEADBEEFCAFEF00D.
- Contention: i_req and d_req held continuously → grants alternate I, D, I, D; each read returns its own address's data; neither waits more than one transaction.
- READ_LAT = 3: load at n → d_rvalid at n+4 exactly; busy high n+1..n+4.
- Reset asserted during WAIT of a load → no d_rvalid, d_rdata = 0, state IDLE after release.
